// File: rtl/lcd_fetch_pkg.sv
// Shared types and helpers for the LCD frame-buffer fetcher.
package lcd_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_FETCH,
        ST_DONE
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned bursts_per_frame(
        input int unsigned h,
        input int unsigned v,
        input int unsigned b
    );
        return (h * v) / b;
    endfunction

endpackage

// File: rtl/lcd_frame_fetcher_credit.sv
// In-flight word tracker and FIFO credit check for burst issue.
module lcd_fetch_credit #(
    parameter int unsigned BURST_LEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        accept_i,
    input  logic        rdv_i,
    input  logic [10:0] fifo_free_i,
    output logic        credit_ok_o,
    output logic        empty_o
);

    localparam logic [11:0] BL = 12'(BURST_LEN);

    logic [11:0]        inflight_q;
    logic [11:0]        inflight_d;
    logic [11:0]        committed;
    logic signed [11:0] room;

    always_comb begin
        inflight_d = inflight_q;
        if (accept_i) begin
            inflight_d = inflight_d + BL;
        end
        if (rdv_i) begin
            inflight_d = inflight_d - 12'd1;
        end
    end

    // A burst accepted this cycle already owns its FIFO space.
    assign committed   = accept_i ? (inflight_q + BL) : inflight_q;
    assign room        = $signed({1'b0, fifo_free_i} - committed);
    assign credit_ok_o = (room >= $signed(BL));
    assign empty_o     = (inflight_q == 12'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= 12'd0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: rtl/lcd_frame_fetcher.sv
// Frame-buffer burst sequencer for LCD scanout with
// frame-boundary double-buffer swap.
module lcd_frame_fetcher
    import lcd_fetch_pkg::*;
#(
    parameter int unsigned H_ACT      = 800,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        next_frame,
    input  logic        swap_req,
    input  logic [31:0] swap_address,
    output logic        swap_done,
    input  logic [10:0] fifo_free,
    output logic        fifo_flush,
    input  logic        fifo_underflow,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [7:0]  mem_burstcount,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    output logic [15:0] underflow_count,
    output logic        busy
);

    if ((H_ACT * V_ACT) % BURST_LEN != 0) begin : g_chk_div
        $error("BURST_LEN must divide H_ACT*V_ACT");
    end
    if (FIFO_DEPTH < BURST_LEN) begin : g_chk_fifo
        $error("FIFO_DEPTH must be at least BURST_LEN");
    end

    localparam int unsigned NBURST = bursts_per_frame(H_ACT, V_ACT, BURST_LEN);
    localparam logic [31:0] LAST_IDX = 32'(NBURST - 1);
    localparam logic [31:0] STRIDE = 32'(BURST_LEN * WORD_BYTES);

    state_e      state_q, state_d;
    logic        nf_prev_q;
    logic [31:0] pending_q, pending_d;
    logic        pflag_q, pflag_d;
    logic [31:0] base_q, base_d;
    logic [31:0] idx_q, idx_d;
    logic        read_q, read_d;
    logic [31:0] addr_q, addr_d;
    logic        abort_q, abort_d;
    logic [15:0] uf_q, uf_d;

    logic fs;
    logic accept;
    logic credit_ok;
    logic drained;

    assign fs     = next_frame & ~nf_prev_q;
    assign accept = read_q & ~mem_waitrequest;

    lcd_fetch_credit #(
        .BURST_LEN(BURST_LEN)
    ) u_credit (
        .clock      (clock),
        .reset      (reset),
        .accept_i   (accept),
        .rdv_i      (mem_readdatavalid),
        .fifo_free_i(fifo_free),
        .credit_ok_o(credit_ok),
        .empty_o    (drained)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pflag_d    = pflag_q;
        base_d     = base_q;
        idx_d      = idx_q;
        read_d     = read_q;
        addr_d     = addr_q;
        abort_d    = abort_q;
        uf_d       = uf_q;
        fifo_flush = 1'b0;
        swap_done  = 1'b0;

        if (swap_req) begin
            pending_d = swap_address;
            pflag_d   = 1'b1;
        end
        if (fifo_underflow && (uf_q != 16'hFFFF)) begin
            uf_d = uf_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (fs) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                fifo_flush = 1'b1;
                swap_done  = pflag_q | swap_req;
                pflag_d    = 1'b0;
                base_d     = pending_d;
                idx_d      = 32'd0;
                state_d    = ST_FETCH;
                if (credit_ok) begin
                    read_d = 1'b1;
                    addr_d = pending_d;
                end
            end
            ST_FETCH: begin
                if (read_q) begin
                    // A frame start seen mid-command waits for acceptance.
                    if (fs) begin
                        abort_d = 1'b1;
                    end
                    if (accept) begin
                        idx_d  = idx_q + 32'd1;
                        read_d = 1'b0;
                        if (fs || abort_q) begin
                            abort_d = 1'b0;
                            state_d = ST_DRAIN;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else if (credit_ok) begin
                            read_d = 1'b1;
                            addr_d = base_q + (idx_q + 32'd1) * STRIDE;
                        end
                    end
                end else if (fs) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    read_d = 1'b1;
                    addr_d = base_q + idx_q * STRIDE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            nf_prev_q <= 1'b1;
            pending_q <= 32'd0;
            pflag_q   <= 1'b0;
            base_q    <= 32'd0;
            idx_q     <= 32'd0;
            read_q    <= 1'b0;
            addr_q    <= 32'd0;
            abort_q   <= 1'b0;
            uf_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            nf_prev_q <= next_frame;
            pending_q <= pending_d;
            pflag_q   <= pflag_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            abort_q   <= abort_d;
            uf_q      <= uf_d;
        end
    end

    assign mem_read        = read_q;
    assign mem_address     = addr_q;
    assign mem_burstcount  = 8'(BURST_LEN);
    assign underflow_count = uf_q;
    assign busy            = (state_q == ST_FLUSH) || (state_q == ST_FETCH);

endmodule

// File: tb/tb_lcd_frame_fetcher.sv
// Self-checking bench for lcd_frame_fetcher: reference model
// plus directed frame, credit, swap, stall, abort and counter cases.
module tb_lcd_frame_fetcher;

    localparam int H  = 160;
    localparam int V  = 16;
    localparam int BL = 32;
    localparam int NB = H * V / BL;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        next_frame = 1'b1;
    logic        swap_req = 1'b0;
    logic [31:0] swap_address = 32'd0;
    logic        swap_done;
    logic [10:0] fifo_free = 11'd1024;
    logic        fifo_flush;
    logic        fifo_underflow = 1'b0;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_burstcount;
    logic        mem_waitrequest = 1'b0;
    logic        mem_readdatavalid = 1'b0;
    logic [15:0] underflow_count;
    logic        busy;

    lcd_frame_fetcher #(
        .H_ACT(H), .V_ACT(V), .BURST_LEN(BL), .FIFO_DEPTH(1024)
    ) dut (
        .clock(clock), .reset(reset), .next_frame(next_frame),
        .swap_req(swap_req), .swap_address(swap_address),
        .swap_done(swap_done), .fifo_free(fifo_free),
        .fifo_flush(fifo_flush), .fifo_underflow(fifo_underflow),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_burstcount(mem_burstcount),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid),
        .underflow_count(underflow_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory responder: returns one word per cycle for words owed.
    bit auto_en = 1'b0;
    int auto_words = 0;
    int granted = 0;
    int emitted = 0;

    always @(negedge clock) begin
        if (auto_en && !reset && mem_read && !mem_waitrequest) begin
            auto_words += BL;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (emitted < auto_words + granted) begin
                mem_readdatavalid = 1'b1;
                emitted++;
            end else begin
                mem_readdatavalid = 1'b0;
            end
        end
    end

    // Reference model, observed at the falling edge.
    logic [31:0] m_base = 0, m_pend = 0, prev_addr = 0;
    logic [31:0] last_acc_addr = 0;
    bit m_pflag = 0;
    int m_idx = 0, m_infl = 0, m_uf = 0;
    bit prev_read = 0, prev_acc = 0, prev_hold = 0;
    bit prev_credit = 0, prev_rst = 1;
    int acc_cnt = 0, flush_cnt = 0;

    always @(negedge clock) begin
        bit acc;
        logic [31:0] exp_addr;
        acc = mem_read && !mem_waitrequest;
        exp_addr = m_base + 32'(m_idx * BL * 4);
        chk("burstcount", mem_burstcount, 64'(BL));
        chk("uf_count", underflow_count, 64'(m_uf));
        chk("swap_done", swap_done, fifo_flush && (m_pflag || swap_req));
        if (!prev_rst) begin
            if (prev_hold) begin
                chk("hold_read", mem_read, 1);
                chk("hold_addr", mem_address, prev_addr);
            end
            if (mem_read) begin
                chk("addr", mem_address, exp_addr);
            end
            if (mem_read && (!prev_read || prev_acc)) begin
                chk("credit", prev_credit, 1);
            end
            if (fifo_flush) begin
                chk("flush_drained", 64'(m_infl), 0);
            end
        end
        prev_credit = (int'(fifo_free) - (m_infl + (acc ? BL : 0))) >= BL;
        prev_read = mem_read;
        prev_acc = acc;
        prev_hold = mem_read && mem_waitrequest;
        prev_addr = mem_address;
        prev_rst = reset;
        if (reset) begin
            m_base = 0; m_pend = 0; m_pflag = 0;
            m_idx = 0; m_infl = 0; m_uf = 0;
        end else begin
            if (fifo_flush) begin
                m_base = swap_req ? swap_address : m_pend;
                m_idx = 0;
                m_pflag = 0;
                flush_cnt++;
            end
            if (swap_req) begin
                m_pend = swap_address;
                if (!fifo_flush) m_pflag = 1;
            end
            if (acc) begin
                m_idx++;
                m_infl += BL;
                acc_cnt++;
                last_acc_addr = mem_address;
            end
            if (mem_readdatavalid) m_infl--;
            if (fifo_underflow && m_uf < 65535) m_uf++;
        end
    end

    initial begin
        int a0;
        int f0;
        bit pr;
        repeat (3) tick();
        chk("rst_read", mem_read, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_sdone", swap_done, 0);
        chk("rst_uf", underflow_count, 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("no_fs_from_reset", busy, 0);
        chk("no_flush_from_reset", 64'(flush_cnt), 0);
        next_frame = 1'b0;
        tick();

        // Full frame with ample credit.
        auto_en = 1'b1;
        a0 = acc_cnt;
        next_frame = 1'b1;
        tick();
        chk("t1_n1_flush", fifo_flush, 0);
        tick();
        chk("t1_n2_flush", fifo_flush, 1);
        chk("t1_n2_busy", busy, 1);
        chk("t1_n2_sdone", swap_done, 0);
        tick();
        chk("t1_n3_read", mem_read, 1);
        chk("t1_n3_addr", mem_address, 0);
        tick();
        chk("t1_n4_read", mem_read, 1);
        chk("t1_n4_addr", mem_address, 32'h80);
        next_frame = 1'b0;
        pr = 1'b0;
        for (int i = 0; i < 20000 && busy; i++) begin
            pr = mem_read;
            tick();
        end
        chk("t1_done", busy, 0);
        chk("t1_fall_after_accept", pr, 1);
        chk("t1_bursts", 64'(acc_cnt - a0), 64'(NB));
        chk("t1_last_addr", last_acc_addr, 32'h2780);
        chk("t1_read_low", mem_read, 0);
        for (int i = 0; i < 5000 && emitted < auto_words; i++) tick();
        chk("t1_drained", 64'(auto_words - emitted), 0);
        auto_en = 1'b0;
        repeat (5) tick();
        chk("t1_no_more", 64'(acc_cnt - a0), 64'(NB));

        // Credit-limited frame; swap request mid-frame.
        fifo_free = 11'd40;
        a0 = acc_cnt;
        next_frame = 1'b1;
        repeat (25) tick();
        chk("t2_one_burst", 64'(acc_cnt - a0), 1);
        chk("t2_read_low", mem_read, 0);
        swap_req = 1'b1;
        swap_address = 32'h0100_0000;
        tick();
        swap_req = 1'b0;
        granted += 32;
        repeat (45) tick();
        chk("t2_two_bursts", 64'(acc_cnt - a0), 2);
        chk("t2_old_base", last_acc_addr, 32'h80);
        chk("t2_read_low2", mem_read, 0);

        // Abort with 64 words in flight.
        fifo_free = 11'd72;
        repeat (5) tick();
        chk("t5_three", 64'(acc_cnt - a0), 3);
        chk("t5_addr", last_acc_addr, 32'h100);
        next_frame = 1'b0;
        tick();
        next_frame = 1'b1;
        f0 = flush_cnt;
        repeat (10) tick();
        chk("t5_no_bursts", 64'(acc_cnt - a0), 3);
        chk("t5_drain_busy", busy, 0);
        mem_waitrequest = 1'b1;
        granted += 63;
        repeat (70) tick();
        chk("t5_no_flush", 64'(flush_cnt - f0), 0);
        granted += 1;
        for (int i = 0; i < 20 && !fifo_flush; i++) tick();
        chk("t5_flush", fifo_flush, 1);
        chk("t5_sdone", swap_done, 1);
        tick();
        chk("t5_restart_read", mem_read, 1);
        chk("t5_restart_addr", mem_address, 32'h0100_0000);

        // Waitrequest stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_read", mem_read, 1);
            chk("t4_hold_addr", mem_address, 32'h0100_0000);
            chk("t4_no_acc", 64'(acc_cnt - a0), 3);
            tick();
        end
        mem_waitrequest = 1'b0;
        tick();
        chk("t4_one_inc", 64'(acc_cnt - a0), 4);
        chk("t4_acc_addr", last_acc_addr, 32'h0100_0000);
        chk("t4_b2b_read", mem_read, 1);
        chk("t4_b2b_addr", mem_address, 32'h0100_0080);
        tick();
        chk("t4_b2b_acc", 64'(acc_cnt - a0), 5);

        // Two swap requests before a frame start: last wins.
        swap_req = 1'b1;
        swap_address = 32'h0200_0000;
        tick();
        swap_req = 1'b0;
        repeat (3) tick();
        swap_req = 1'b1;
        swap_address = 32'h0300_0000;
        tick();
        swap_req = 1'b0;
        next_frame = 1'b0;
        tick();
        next_frame = 1'b1;
        tick();
        granted += 64;
        for (int i = 0; i < 150 && !fifo_flush; i++) tick();
        chk("t3_flush", fifo_flush, 1);
        chk("t3_sdone", swap_done, 1);
        tick();
        chk("t3_read", mem_read, 1);
        chk("t3_addr", mem_address, 32'h0300_0000);

        // Reset while a command is stalled.
        mem_waitrequest = 1'b1;
        repeat (2) tick();
        chk("rst_mid_pre", mem_read, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_read", mem_read, 0);
        chk("rst_mid_busy", busy, 0);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        repeat (3) tick();
        chk("rst_mid_idle", busy, 0);

        // Underflow counter and saturation.
        fifo_underflow = 1'b1;
        repeat (3) tick();
        fifo_underflow = 1'b0;
        chk("uf_three", underflow_count, 3);
        fifo_underflow = 1'b1;
        repeat (70000) tick();
        fifo_underflow = 1'b0;
        tick();
        chk("uf_sat", underflow_count, 16'hFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("uf_clear", underflow_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
